// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of an asynchronous FIFO: pointer, full/almost-full flags and level, all on write_clk.
// Define FIFO_WR_OVF_CNT_EN to add a saturating 16-bit ovf_count output.
module fifo_wr_ctrl #(
   parameter int RAM_WIDTH   = 8,
   parameter int ADDR_WIDTH  = 4,
   parameter int AFULL_LEVEL = 2**ADDR_WIDTH - 2
) (
   input  logic                  write_clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [RAM_WIDTH-1:0]  wr_data,
   input  logic [ADDR_WIDTH:0]   rd_ptr_gray,
   output logic                  write_allow,
   output logic [ADDR_WIDTH-1:0] write_addr,
   output logic [RAM_WIDTH-1:0]  write_data,
   output logic [ADDR_WIDTH:0]   wr_ptr_gray,
   output logic                  wr_full,
   output logic                  wr_almost_full,
   output logic [ADDR_WIDTH:0]   wr_level,
   output logic                  wr_overflow
`ifdef FIFO_WR_OVF_CNT_EN
   ,
   output logic [15:0]           ovf_count
`endif
);

   localparam int PW = ADDR_WIDTH + 1;
   localparam logic [PW-1:0] AFULL = PW'(AFULL_LEVEL);

   logic [PW-1:0] wr_ptr_bin;
   logic [PW-1:0] rd_sync1;
   logic [PW-1:0] rd_sync;
   logic          run;
   logic          accept;
   logic [PW-1:0] ptr_next;
   logic [PW-1:0] gray_next;
   logic [PW-1:0] rd_bin;
   logic [PW-1:0] level_next;
   logic          full_next;
   logic          afull_next;

   function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
      logic [PW-1:0] b;
      b = '0;
      for (int i = 0; i < PW; i++) begin
         b[i] = ^(g >> i);
      end
      return b;
   endfunction

   // run holds pushes off for the first edge after reset release.
   always_comb begin
      accept     = wr_en & ~wr_full & run;
      ptr_next   = wr_ptr_bin + {{(PW-1){1'b0}}, accept};
      gray_next  = ptr_next ^ (ptr_next >> 1);
      rd_bin     = gray2bin(rd_sync);
      level_next = ptr_next - rd_bin;
      full_next  = (gray_next == {~rd_sync[ADDR_WIDTH:ADDR_WIDTH-1], rd_sync[ADDR_WIDTH-2:0]});
      afull_next = (level_next >= AFULL);
   end

   always_ff @(posedge write_clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_sync1       <= '0;
         rd_sync        <= '0;
         run            <= 1'b0;
         wr_ptr_bin     <= '0;
         wr_ptr_gray    <= '0;
         wr_full        <= 1'b0;
         wr_almost_full <= 1'b0;
         wr_level       <= '0;
         wr_overflow    <= 1'b0;
         write_allow    <= 1'b0;
         write_addr     <= '0;
         write_data     <= '0;
      end else begin
         rd_sync1       <= rd_ptr_gray;
         rd_sync        <= rd_sync1;
         run            <= 1'b1;
         wr_ptr_bin     <= ptr_next;
         wr_ptr_gray    <= gray_next;
         wr_full        <= full_next;
         wr_almost_full <= afull_next;
         wr_level       <= level_next;
         wr_overflow    <= wr_en & wr_full;
         write_allow    <= accept;
         if (accept) begin
            write_addr <= wr_ptr_bin[ADDR_WIDTH-1:0];
            write_data <= wr_data;
         end
      end
   end

`ifdef FIFO_WR_OVF_CNT_EN
   always_ff @(posedge write_clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_count <= '0;
      end else if (wr_en && wr_full && ovf_count != 16'hFFFF) begin
         ovf_count <= ovf_count + 16'd1;
      end
   end
`endif

endmodule
